up_heartbeat_merger: RTL and testbench

Upstream-side merge stage that consumes heartbeat requests from the time manager and interleaves them with the BD-to-PC word stream. Each heartbeat carries the current time value and is emitted as an atomic two-word packet (low half, then high half) on the single registered upstream output channel that feeds the PC link serializer. Arbitration is round-robin between heartbeat packets and BD words, so neither source starves.

---
 rtl/UpstreamPkg.sv | 21 ++
 rtl/up_out_reg.sv | 31 +++
 rtl/up_heartbeat_merger.sv | 115 +++++++++++
 tb/tb_up_heartbeat_merger.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/UpstreamPkg.sv
// Shared definitions for the upstream merge stages: word codes, grant source, FSM states.
package UpstreamPkg;

   localparam int unsigned CodeW = 8;

   // Code field prepended to every upstream word
   localparam logic [CodeW-1:0] HB_LO_CODE = 8'hA1;
   localparam logic [CodeW-1:0] HB_HI_CODE = 8'hA2;
   localparam logic [CodeW-1:0] BD_CODE    = 8'hB0;

   typedef enum logic {
      GrantBd,
      GrantHb
   } grant_e;

   typedef enum logic {
      StIdle,
      StHbHi
   } state_e;

endpackage

// File: rtl/up_out_reg.sv
// Registered single-entry valid/data output slot shared by the upstream merge stages.
// The slot is free when empty or when its word is being consumed this cycle.
module up_out_reg #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [Width-1:0] load_d,
   input  logic             out_a,
   output logic             out_v,
   output logic [Width-1:0] out_d,
   output logic             slot_free
);

   assign slot_free = !out_v || out_a;

   // Load a new word, or drop valid once the held word is accepted; data held otherwise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_v <= 1'b0;
         out_d <= '0;
      end else if (load) begin
         out_v <= 1'b1;
         out_d <= load_d;
      end else if (out_a) begin
         out_v <= 1'b0;
      end
   end

endmodule

// File: rtl/up_heartbeat_merger.sv
// Round-robin merge of two-word heartbeat packets with the BD upstream word stream.
// Optional macro UP_HB_COALESCE_EN: newest pending heartbeat overwrites an older one.
module up_heartbeat_merger
   import UpstreamPkg::*;
#(
   parameter int unsigned Ntime = 48,
   parameter int unsigned Npay  = 24,
   parameter int unsigned Ncode = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hb_v,
   input  logic [Ntime-1:0]       hb_d,
   output logic                   hb_a,
   input  logic                   bd_v,
   input  logic [Npay-1:0]        bd_d,
   output logic                   bd_a,
   output logic                   out_v,
   output logic [Ncode+Npay-1:0]  out_d,
   input  logic                   out_a
);

   state_e                  state_q, state_d;
   grant_e                  last_q, last_d;
   logic                    hb_full_q;
   logic [Ntime-1:0]        hb_val_q;
   logic                    slot_free;
   logic                    load;
   logic [Ncode+Npay-1:0]   load_d;
   logic                    hb_grant;
   logic                    hb_clear;

   up_out_reg #(
      .Width (Ncode + Npay)
   ) u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .load_d    (load_d),
      .out_a     (out_a),
      .out_v     (out_v),
      .out_d     (out_d),
      .slot_free (slot_free)
   );

   // Arbitration and packet sequencing; LO and HI halves are always loaded back to back
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      load     = 1'b0;
      load_d   = '0;
      bd_a     = 1'b0;
      hb_grant = 1'b0;
      hb_clear = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (slot_free) begin
               if (hb_full_q && (last_q == GrantBd || !bd_v)) begin
                  hb_grant = 1'b1;
                  load     = 1'b1;
                  load_d   = {Ncode'(HB_LO_CODE), hb_val_q[Npay-1:0]};
                  last_d   = GrantHb;
                  state_d  = StHbHi;
               end else if (bd_v) begin
                  bd_a   = 1'b1;
                  load   = 1'b1;
                  load_d = {Ncode'(BD_CODE), bd_d};
                  last_d = GrantBd;
               end
            end
         end
         StHbHi: begin
            if (slot_free) begin
               load     = 1'b1;
               load_d   = {Ncode'(HB_HI_CODE), hb_val_q[Ntime-1:Npay]};
               hb_clear = 1'b1;
               state_d  = StIdle;
            end
         end
      endcase
   end

`ifdef UP_HB_COALESCE_EN
   // Accept freely, except while a packet is being built from hb_val: the grant cycle
   // and the HI-pending state both still read it.
   assign hb_a = (state_q == StIdle) && !hb_grant;
`else
   assign hb_a = !hb_full_q;
`endif

   // FSM state and round-robin pointer; BD counts as last so heartbeat wins first contention
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         last_q  <= GrantBd;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // One-entry heartbeat holding register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hb_full_q <= 1'b0;
         hb_val_q  <= '0;
      end else if (hb_v && hb_a) begin
         hb_full_q <= 1'b1;
         hb_val_q  <= hb_d;
      end else if (hb_clear) begin
         hb_full_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_up_heartbeat_merger.sv
// Self-checking bench for up_heartbeat_merger: directed steps, then random traffic
// against a queue-based scoreboard. Covers UP_HB_COALESCE_EN when defined.
module tb_up_heartbeat_merger;
   import UpstreamPkg::*;

   localparam int unsigned Ntime = 48;
   localparam int unsigned Npay  = 24;
   localparam int unsigned Ncode = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  hb_v;
   logic [Ntime-1:0]      hb_d;
   logic                  hb_a;
   logic                  bd_v;
   logic [Npay-1:0]       bd_d;
   logic                  bd_a;
   logic                  out_v;
   logic [Ncode+Npay-1:0] out_d;
   logic                  out_a;

   int total = 0;
   int bad   = 0;

   // Scoreboard state
   logic [Ntime-1:0]      hbq[$];
   logic [Npay-1:0]       bdq[$];
   logic [Ntime-1:0]      cur_hb;
   logic                  expect_hi;
   logic                  prev_stall;
   logic [Ncode+Npay-1:0] prev_d;
   int                    bd_since;

   up_heartbeat_merger #(
      .Ntime (Ntime),
      .Npay  (Npay),
      .Ncode (Ncode)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hb_v  (hb_v),
      .hb_d  (hb_d),
      .hb_a  (hb_a),
      .bd_v  (bd_v),
      .bd_d  (bd_d),
      .bd_a  (bd_a),
      .out_v (out_v),
      .out_d (out_d),
      .out_a (out_a)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [7:0] code, input logic [23:0] pay);
      return {code, pay};
   endfunction

   // Called at the falling edge: handshakes seen now complete at the next rising edge
   task automatic observe();
      logic [7:0]  code;
      logic [23:0] pay;
      code = out_d[31:24];
      pay  = out_d[23:0];
      if (prev_stall) begin
         chk("stall_valid", 64'(out_v), 64'd1);
         chk("stall_data", 64'(out_d), 64'(prev_d));
      end
      if (out_v && out_a) begin
         if (expect_hi) begin
            chk("hi_code", 64'(code), 64'(HB_HI_CODE));
            chk("hi_pay", 64'(pay), 64'(cur_hb[47:24]));
            expect_hi = 1'b0;
         end else if (code == HB_LO_CODE) begin
            chk("lo_pending", 64'(hbq.size() > 0), 64'd1);
            if (hbq.size() > 0) cur_hb = hbq.pop_front();
            chk("lo_pay", 64'(pay), 64'(cur_hb[23:0]));
            expect_hi = 1'b1;
         end else begin
            chk("bd_code", 64'(code), 64'(BD_CODE));
            chk("bd_pending", 64'(bdq.size() > 0), 64'd1);
            if (bdq.size() > 0) chk("bd_pay", 64'(pay), 64'(bdq.pop_front()));
            if (hbq.size() > 0) begin
               bd_since++;
               chk("fairness", 64'(bd_since <= 1), 64'd1);
            end
         end
      end
      prev_stall = out_v && !out_a;
      prev_d     = out_d;
      if (hb_v && hb_a) begin
         if (hbq.size() == 0) bd_since = 0;
`ifdef UP_HB_COALESCE_EN
         hbq.delete();
`endif
         hbq.push_back(hb_d);
      end
      if (bd_v && bd_a) bdq.push_back(bd_d);
   endtask

   initial begin
      reset = 1'b0;
      hb_v  = 1'b0;
      hb_d  = '0;
      bd_v  = 1'b0;
      bd_d  = '0;
      out_a = 1'b1;
      expect_hi  = 1'b0;
      prev_stall = 1'b0;
      prev_d     = '0;
      cur_hb     = '0;
      bd_since   = 0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_v", 64'(out_v), 64'd0);
      chk("rst_out_d", 64'(out_d), 64'd0);
      chk("rst_hb_a", 64'(hb_a), 64'd1);
      chk("rst_bd_a", 64'(bd_a), 64'd0);
      @(posedge clk); #1 reset = 1'b1;

      // Heartbeat only
      hb_v = 1'b1; hb_d = 48'hABCDEF_123456;
      @(negedge clk) chk("hb1_accept", 64'(hb_a), 64'd1);
      @(posedge clk); #1 hb_v = 1'b0;
      @(negedge clk);
      chk("hb1_busy", 64'(hb_a), 64'd0);
      chk("hb1_gap", 64'(out_v), 64'd0);
      @(negedge clk) chk("hb1_lo", 64'(out_d), 64'(word(HB_LO_CODE, 24'h123456)));
      @(negedge clk) chk("hb1_hi", 64'(out_d), 64'(word(HB_HI_CODE, 24'hABCDEF)));
      @(negedge clk);
      chk("hb1_done_v", 64'(out_v), 64'd0);
      chk("hb1_done_a", 64'(hb_a), 64'd1);

      // Simultaneous heartbeat and BD from empty
      @(posedge clk); #1 hb_v = 1'b1; hb_d = 48'h111111_222222; bd_v = 1'b1; bd_d = 24'h5A5A5A;
      @(negedge clk);
      chk("sim_bd_a", 64'(bd_a), 64'd1);
      chk("sim_hb_a", 64'(hb_a), 64'd1);
      @(posedge clk); #1 hb_v = 1'b0; bd_v = 1'b0;
      @(negedge clk) chk("sim_bd", 64'(out_d), 64'(word(BD_CODE, 24'h5A5A5A)));
      @(negedge clk) chk("sim_lo", 64'(out_d), 64'(word(HB_LO_CODE, 24'h222222)));
      @(negedge clk) chk("sim_hi", 64'(out_d), 64'(word(HB_HI_CODE, 24'h111111)));

      // BD throughput: one word per cycle, one cycle latency
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1 bd_v = 1'b1; bd_d = 24'(32'h300 + k);
         @(negedge clk);
         chk("bd_thr_a", 64'(bd_a), 64'd1);
         if (k > 0) chk("bd_thr_d", 64'(out_d), 64'(word(BD_CODE, 24'(32'h300 + k - 1))));
      end
      @(posedge clk); #1 bd_v = 1'b0;
      @(negedge clk) chk("bd_thr_last", 64'(out_d), 64'(word(BD_CODE, 24'h303)));

      // Output stalled with heartbeat LO held
      @(posedge clk); #1 out_a = 1'b0; hb_v = 1'b1; hb_d = 48'hCAFE00_BEEF11;
      @(posedge clk); #1 hb_v = 1'b0;
      @(posedge clk); #1 hb_v = 1'b1; hb_d = 48'h999999_888888; bd_v = 1'b1; bd_d = 24'h444444;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_lo", 64'(out_d), 64'(word(HB_LO_CODE, 24'hBEEF11)));
         chk("stall_v", 64'(out_v), 64'd1);
         chk("stall_bd_a", 64'(bd_a), 64'd0);
         chk("stall_hb_a", 64'(hb_a), 64'd0);
         @(posedge clk); #1;
      end
      hb_v = 1'b0; bd_v = 1'b0; out_a = 1'b1;
      @(negedge clk) chk("unstall_lo", 64'(out_d), 64'(word(HB_LO_CODE, 24'hBEEF11)));
      @(negedge clk) chk("unstall_hi", 64'(out_d), 64'(word(HB_HI_CODE, 24'hCAFE00)));
      @(negedge clk) chk("unstall_idle", 64'(out_v), 64'd0);

`ifdef UP_HB_COALESCE_EN
      // Two heartbeats while the output is stalled: newest time wins
      @(posedge clk); #1 out_a = 1'b0; bd_v = 1'b1; bd_d = 24'h777777;
      @(posedge clk); #1 bd_v = 1'b0; hb_v = 1'b1; hb_d = 48'h1;
      @(negedge clk) chk("coal_a1", 64'(hb_a), 64'd1);
      @(posedge clk); #1 hb_d = 48'h2;
      @(negedge clk) chk("coal_a2", 64'(hb_a), 64'd1);
      @(posedge clk); #1 hb_v = 1'b0; out_a = 1'b1;
      @(negedge clk) chk("coal_bd", 64'(out_d), 64'(word(BD_CODE, 24'h777777)));
      @(negedge clk) chk("coal_lo", 64'(out_d), 64'(word(HB_LO_CODE, 24'h000002)));
      @(negedge clk) chk("coal_hi", 64'(out_d), 64'(word(HB_HI_CODE, 24'h000000)));
      @(negedge clk) chk("coal_idle", 64'(out_v), 64'd0);
`endif

      // Reset between LO and HI
      @(posedge clk); #1 hb_v = 1'b1; hb_d = 48'hDEAD00_00BEEF;
      @(posedge clk); #1 hb_v = 1'b0;
      @(posedge clk); #1;
      chk("mid_lo", 64'(out_d), 64'(word(HB_LO_CODE, 24'h00BEEF)));
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_v", 64'(out_v), 64'd0);
      chk("mid_rst_a", 64'(hb_a), 64'd1);
      @(posedge clk); #1 reset = 1'b1;
      hb_v = 1'b1; hb_d = 48'h654321_0FEDCB;
      @(posedge clk); #1 hb_v = 1'b0;
      @(negedge clk) chk("post_gap", 64'(out_v), 64'd0);
      @(negedge clk) chk("post_lo", 64'(out_d), 64'(word(HB_LO_CODE, 24'h0FEDCB)));
      @(negedge clk) chk("post_hi", 64'(out_d), 64'(word(HB_HI_CODE, 24'h654321)));
      @(negedge clk) chk("post_idle", 64'(out_v), 64'd0);

      // Random traffic with backpressure
      for (int n = 0; n < 10000; n++) begin
         @(posedge clk); #1;
         hb_v  = ($urandom_range(3) == 0);
         hb_d  = {16'($urandom), $urandom};
         bd_v  = ($urandom_range(1) == 1);
         bd_d  = 24'($urandom);
         out_a = ($urandom_range(9) < 7);
         @(negedge clk);
         observe();
      end

      // Drain with a bounded wait
      @(posedge clk); #1 hb_v = 1'b0; bd_v = 1'b0; out_a = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         observe();
         @(posedge clk); #1;
      end
      chk("drain_hb", 64'(hbq.size()), 64'd0);
      chk("drain_bd", 64'(bdq.size()), 64'd0);
      chk("drain_hi", 64'(expect_hi), 64'd0);
      chk("drain_out_v", 64'(out_v), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
